// File: rtl/crop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crop_pkg
//  Description : Shared geometry defaults, counter widths and FSM state type
//                for the crop filter sequencing logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package crop_pkg;

    localparam int DEF_IN_ROWS  = 20;
    localparam int DEF_IN_COLS  = 20;
    localparam int DEF_OUT_ROWS = 10;
    localparam int DEF_OUT_COLS = 10;

    localparam int COL_W = $clog2(DEF_IN_COLS);
    localparam int ROW_W = $clog2(DEF_IN_ROWS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        STOPPING = 2'd2
    } crop_state_t;

endpackage
`default_nettype wire

// File: rtl/crop_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : crop_raster_counter
//  Description : Column/row raster counters advanced per accepted beat, with
//                wrap at the frame edges and a combinational last-beat flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module crop_raster_counter #(
    parameter int IN_ROWS = 20,
    parameter int IN_COLS = 20
) (
    input  logic                       clk,
    input  logic                       srst_n,
    input  logic                       clear,
    input  logic                       beat,
    output logic [$clog2(IN_COLS)-1:0] cnt_col,
    output logic [$clog2(IN_ROWS)-1:0] cnt_row,
    output logic                       last_beat
);

    localparam int CW = $clog2(IN_COLS);
    localparam int RW = $clog2(IN_ROWS);

    logic col_end;
    logic row_end;

    assign col_end   = (cnt_col == CW'(IN_COLS - 1));
    assign row_end   = (cnt_row == RW'(IN_ROWS - 1));
    assign last_beat = beat && col_end && row_end;

    // Advance the raster position once per beat; clear holds it at the origin.
    always_ff @(posedge clk) begin
        if (!srst_n || clear) begin
            cnt_col <= '0;
            cnt_row <= '0;
        end else if (beat) begin
            if (col_end) begin
                cnt_col <= '0;
                cnt_row <= row_end ? '0 : cnt_row + RW'(1);
            end else begin
                cnt_col <= cnt_col + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/crop_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : crop_scheduler
//  Description : Sequencing controller for the crop filter. Tags each upstream
//                beat with its raster position and swaps in a new crop origin
//                only on a frame boundary.
//  Options     : CROP_WINDOW_CHECK_EN adds the sticky window_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module crop_scheduler
    import crop_pkg::*;
#(
    parameter int IN_ROWS  = DEF_IN_ROWS,
    parameter int IN_COLS  = DEF_IN_COLS,
    parameter int OUT_ROWS = DEF_OUT_ROWS,
    parameter int OUT_COLS = DEF_OUT_COLS
) (
    input  logic                       clk,
    input  logic                       srst_n,
    input  logic                       enable,
    input  logic                       cfg_wr,
    input  logic [$clog2(IN_COLS)-1:0] cfg_x0,
    input  logic [$clog2(IN_ROWS)-1:0] cfg_y0,
    input  logic                       beat_valid,
    input  logic                       beat_ready,
    output logic [$clog2(IN_COLS)-1:0] cnt_col,
    output logic [$clog2(IN_ROWS)-1:0] cnt_row,
    output logic [$clog2(IN_COLS)-1:0] crop_x0,
    output logic [$clog2(IN_ROWS)-1:0] crop_y0,
    output logic                       cfg_pending,
    output logic                       cfg_clamped,
    output logic                       busy,
`ifdef CROP_WINDOW_CHECK_EN
    output logic                       window_err,
`endif
    output logic                       frame_done,
    output logic [15:0]                frame_cnt
);

    localparam int CW = $clog2(IN_COLS);
    localparam int RW = $clog2(IN_ROWS);
    // One extra bit so an out-of-range request cannot wrap during the compare.
    localparam logic [CW:0] MAX_X = (CW+1)'(IN_COLS - OUT_COLS);
    localparam logic [RW:0] MAX_Y = (RW+1)'(IN_ROWS - OUT_ROWS);

    crop_state_t   state;
    crop_state_t   state_nx;
    logic          beat;
    logic          last_beat;
    logic          at_origin;
    logic          clamp_x;
    logic          clamp_y;
    logic [CW-1:0] x_sat;
    logic [RW-1:0] y_sat;
    logic [CW-1:0] pend_x;
    logic [RW-1:0] pend_y;
    logic          apply;

    assign busy      = (state != IDLE);
    assign beat      = beat_valid && beat_ready && busy;
    assign at_origin = (cnt_col == '0) && (cnt_row == '0);

    assign clamp_x = ({1'b0, cfg_x0} > MAX_X);
    assign clamp_y = ({1'b0, cfg_y0} > MAX_Y);
    assign x_sat   = clamp_x ? MAX_X[CW-1:0] : cfg_x0;
    assign y_sat   = clamp_y ? MAX_Y[RW-1:0] : cfg_y0;

    // Origin changes only when a run starts or on the last beat of a frame.
    assign apply = ((state == IDLE) && enable) || (last_beat && (cfg_pending || cfg_wr));

    crop_raster_counter #(
        .IN_ROWS (IN_ROWS),
        .IN_COLS (IN_COLS)
    ) u_raster (
        .clk       (clk),
        .srst_n    (srst_n),
        .clear     (state == IDLE),
        .beat      (beat),
        .cnt_col   (cnt_col),
        .cnt_row   (cnt_row),
        .last_beat (last_beat)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!srst_n) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state: stopping always waits for the frame's last beat unless the
    // stream is still parked at the origin with nothing accepted.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (enable) state_nx = ACTIVE;
            ACTIVE:   if (!enable) state_nx = (last_beat || (at_origin && !beat)) ? IDLE : STOPPING;
            STOPPING: if (enable) state_nx = ACTIVE;
                      else if (last_beat) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Shadow origin, clamp flag and boundary apply; a write on the applying
    // edge bypasses the shadow so the newest request always wins.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            pend_x      <= '0;
            pend_y      <= '0;
            crop_x0     <= '0;
            crop_y0     <= '0;
            cfg_pending <= 1'b0;
            cfg_clamped <= 1'b0;
        end else begin
            if (cfg_wr) begin
                pend_x      <= x_sat;
                pend_y      <= y_sat;
                cfg_clamped <= clamp_x || clamp_y;
            end
            if (apply) begin
                crop_x0     <= cfg_wr ? x_sat : pend_x;
                crop_y0     <= cfg_wr ? y_sat : pend_y;
                cfg_pending <= 1'b0;
            end else if (cfg_wr) begin
                cfg_pending <= 1'b1;
            end
        end
    end

    // Frame completion pulse and wrapping frame counter.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= last_beat;
            if (last_beat) frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef CROP_WINDOW_CHECK_EN
    localparam int          WW    = $clog2(IN_ROWS * IN_COLS + 1);
    localparam logic [WW-1:0] WIN_N = WW'(OUT_ROWS * OUT_COLS);

    logic [WW-1:0] win_cnt;
    logic          in_win;
    logic [CW:0]   x_lo;
    logic [RW:0]   y_lo;

    assign x_lo   = {1'b0, crop_x0};
    assign y_lo   = {1'b0, crop_y0};
    assign in_win = ({1'b0, cnt_col} >= x_lo) && ({1'b0, cnt_col} < x_lo + (CW+1)'(OUT_COLS)) &&
                    ({1'b0, cnt_row} >= y_lo) && ({1'b0, cnt_row} < y_lo + (RW+1)'(OUT_ROWS));

    // Count in-window beats per frame and flag a wrong total at frame end.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            win_cnt    <= '0;
            window_err <= 1'b0;
        end else begin
            if (state == IDLE || last_beat) win_cnt <= '0;
            else if (beat && in_win)        win_cnt <= win_cnt + WW'(1);
            if (last_beat && ((win_cnt + WW'(in_win)) != WIN_N)) window_err <= 1'b1;
            else if (cfg_wr)                                     window_err <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire
